// File: rtl/axi_store_writer_pkg.sv
// Shared types and AXI constants for the single-beat store writer.
package axi_store_writer_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } store_size_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } wr_state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  function automatic logic [3:0] size_bytes(input store_size_t size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/axi_store_writer_lane_align.sv
// Places right-justified store data onto its byte lanes of the 64-bit bus
// and flags accesses that are not naturally aligned or cross the 8-byte word.
module axi_store_writer_lane_align
  import axi_store_writer_pkg::*;
(
  input  logic [2:0]  i_addr_lo,
  input  store_size_t i_size,
  input  logic [63:0] i_data,
  output logic [63:0] o_wdata,
  output logic [7:0]  o_wstrb,
  output logic        o_misaligned
);

  logic [3:0] w_nbytes;
  logic [3:0] w_start;
  logic [3:0] w_end;

  assign w_nbytes = size_bytes(i_size);
  assign w_start  = {1'b0, i_addr_lo};
  assign w_end    = w_start + w_nbytes;

  assign o_misaligned = (w_end > 4'd8) || ((w_start & (w_nbytes - 4'd1)) != 4'd0);
  assign o_wdata      = i_data << {i_addr_lo, 3'b000};

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_strb
      assign o_wstrb[gi] = (4'(gi) >= w_start) && (4'(gi) < w_end);
    end
  endgenerate

endmodule

// File: rtl/axi_store_writer.sv
// MEM-stage store master: one request at a time becomes a single-beat AXI
// write; completion is a one-cycle done pulse with an error flag.
module axi_store_writer
  import axi_store_writer_pkg::*;
#(
  parameter int                     ID_WIDTH   = 13,
  parameter int                     ADDR_WIDTH = 64,
  parameter int                     DATA_WIDTH = 64,
  parameter int                     STRB_WIDTH = DATA_WIDTH / 8,
  parameter logic [ID_WIDTH-1:0]    WR_ID      = '0
) (
  input  logic                    clk,
  input  logic                    reset,

  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [DATA_WIDTH-1:0]   req_data,
  input  logic [1:0]              req_size,
  output logic                    busy,
  output logic                    done,
  output logic                    done_err,

  output logic [ID_WIDTH-1:0]     m_axi_awid,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic                    m_axi_awlock,
  output logic [3:0]              m_axi_awcache,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,

  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [STRB_WIDTH-1:0]   m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,

  input  logic [ID_WIDTH-1:0]     m_axi_bid,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready
);

  wr_state_t r_state;
  wr_state_t w_state_next;

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [1:0]            r_size;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_WIDTH-1:0] r_wstrb;
  logic                  r_aw_done;
  logic                  r_w_done;
  logic                  r_err;

  logic                  w_accept;
  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_b_hs;
  logic                  w_aw_done_next;
  logic                  w_w_done_next;
  logic                  w_misaligned;
  logic [DATA_WIDTH-1:0] w_lane_wdata;
  logic [STRB_WIDTH-1:0] w_lane_wstrb;

  // Lane placement is computed from the live request so the misalignment
  // verdict is available in the accept cycle; results are then latched.
  axi_store_writer_lane_align u_lane_align (
    .i_addr_lo    (req_addr[2:0]),
    .i_size       (store_size_t'(req_size)),
    .i_data       (req_data),
    .o_wdata      (w_lane_wdata),
    .o_wstrb      (w_lane_wstrb),
    .o_misaligned (w_misaligned)
  );

  assign w_accept       = (r_state == ST_IDLE) && req_valid;
  assign w_aw_hs        = m_axi_awvalid && m_axi_awready;
  assign w_w_hs         = m_axi_wvalid && m_axi_wready;
  assign w_b_hs         = m_axi_bvalid && m_axi_bready;
  assign w_aw_done_next = r_aw_done || w_aw_hs;
  assign w_w_done_next  = r_w_done || w_w_hs;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (req_valid) w_state_next = w_misaligned ? ST_DONE : ST_SEND;
      ST_SEND: if (w_aw_done_next && w_w_done_next) w_state_next = ST_RESP;
      ST_RESP: if (m_axi_bvalid) w_state_next = ST_DONE;
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // req_ready is also gated by reset so every handshake output reads 0 while held.
  always_comb begin
    req_ready     = (r_state == ST_IDLE) && !reset;
    busy          = (r_state != ST_IDLE);
    m_axi_awvalid = (r_state == ST_SEND) && !r_aw_done;
    m_axi_wvalid  = (r_state == ST_SEND) && !r_w_done;
    m_axi_bready  = (r_state == ST_RESP);
    done          = (r_state == ST_DONE);
    done_err      = (r_state == ST_DONE) && r_err;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr    <= '0;
      r_size    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr    <= req_addr;
        r_size    <= req_size;
        r_wdata   <= w_lane_wdata;
        r_wstrb   <= w_lane_wstrb;
        r_err     <= w_misaligned;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
      if (r_state == ST_SEND) begin
        r_aw_done <= w_aw_done_next;
        r_w_done  <= w_w_done_next;
      end
      if ((r_state == ST_RESP) && w_b_hs) begin
        r_err <= (m_axi_bresp != RESP_OKAY) || (m_axi_bid != WR_ID);
      end
    end
  end

  assign m_axi_awid    = WR_ID;
  assign m_axi_awaddr  = r_addr;
  assign m_axi_awlen   = 8'd0;
  assign m_axi_awsize  = {1'b0, r_size};
  assign m_axi_awburst = BURST_INCR;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'd0;
  assign m_axi_awprot  = 3'd0;

  assign m_axi_wdata   = r_wdata;
  assign m_axi_wstrb   = r_wstrb;
  assign m_axi_wlast   = 1'b1;

endmodule

// File: tb/tb_axi_store_writer.sv
// Scoreboard bench for axi_store_writer: directed scenarios plus random stores,
// with a simple AXI slave that also checks AW/W payloads against expectations.
module tb_axi_store_writer;

  localparam int              ID_WIDTH = 13;
  localparam logic [12:0]     WR_ID    = 13'd0;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic [63:0] req_data;
  logic [1:0]  req_size;
  logic        busy, done, done_err;
  logic [12:0] awid;
  logic [63:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid, awready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [12:0] bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  axi_store_writer #(.ID_WIDTH(ID_WIDTH), .WR_ID(WR_ID)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_data(req_data), .req_size(req_size), .busy(busy), .done(done),
    .done_err(done_err),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen),
    .m_axi_awsize(awsize), .m_axi_awburst(awburst), .m_axi_awlock(awlock),
    .m_axi_awcache(awcache), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid),
    .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid),
    .m_axi_bready(bready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] addr; logic [1:0] size; } aw_exp_t;
  typedef struct { logic [63:0] data; logic [7:0] strb; } w_exp_t;
  typedef struct { logic err; int lat; } d_exp_t;

  aw_exp_t aw_q[$];
  w_exp_t  w_q[$];
  d_exp_t  d_q[$];

  int n_cmp = 0;
  int n_mis = 0;
  int cyc = 0;

  // Stimulus-side knobs the slave follows for the transaction in flight
  int          t0 = 0;
  int          cur_aw_d = 1, cur_w_d = 1, cur_b_d = 0;
  logic [1:0]  cur_bresp = 2'b00;
  logic [12:0] cur_bid = 13'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_mis++;
    $display("FAIL %s actual=timeout required=event (cycle %0d)", nm, cyc);
  endtask

  // AXI slave + AW/W monitor. Readies and bvalid are set on the negedge, so
  // valid&&ready observed 1 time unit later is the handshake of the next posedge.
  initial begin : slave
    bit aw_seen = 0, w_seen = 0, b_fire = 0;
    int b_cnt = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        awready = 0; wready = 0; bvalid = 0;
        aw_seen = 0; w_seen = 0; b_fire = 0; b_cnt = 0;
        continue;
      end
      if (b_fire) begin
        bvalid = 0; b_fire = 0; aw_seen = 0; w_seen = 0; b_cnt = 0;
      end
      awready = ((cyc - t0) >= cur_aw_d);
      wready  = ((cyc - t0) >= cur_w_d);
      if (aw_seen && w_seen && !bvalid) begin
        if (b_cnt >= cur_b_d) begin
          bvalid = 1; bresp = cur_bresp; bid = cur_bid;
        end else begin
          b_cnt++;
        end
      end
      #1;
      if (bready) chk("bready_early", 64'(aw_seen && w_seen), 64'd1);
      if (aw_seen) chk("awvalid_drop", 64'(awvalid), 64'd0);
      if (w_seen) chk("wvalid_drop", 64'(wvalid), 64'd0);
      if (awvalid && !aw_seen) begin
        if (aw_q.size() == 0) fail_now("aw_unexpected");
        else begin
          chk("awaddr", awaddr, aw_q[0].addr);
          chk("awsize", 64'(awsize), 64'(aw_q[0].size));
          chk("aw_fixed", {awid, awlen, awburst, awlock, awcache, awprot},
              {WR_ID, 8'd0, 2'b01, 1'b0, 4'd0, 3'd0});
          if (awready) begin aw_seen = 1; void'(aw_q.pop_front()); end
        end
      end
      if (wvalid && !w_seen) begin
        if (w_q.size() == 0) fail_now("w_unexpected");
        else begin
          chk("wdata", wdata, w_q[0].data);
          chk("wstrb", 64'(wstrb), 64'(w_q[0].strb));
          chk("wlast", 64'(wlast), 64'd1);
          if (wready) begin w_seen = 1; void'(w_q.pop_front()); end
        end
      end
      if (bvalid && bready) b_fire = 1;
    end
  end

  // Completion monitor
  initial begin : done_mon
    d_exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (done) begin
        if (d_q.size() == 0) fail_now("done_unexpected");
        else begin
          e = d_q.pop_front();
          chk("done_err", 64'(done_err), 64'(e.err));
          chk("done_latency", 64'(cyc - t0), 64'(e.lat));
          chk("busy_in_done", 64'(busy), 64'd1);
          chk("req_ready_in_done", 64'(req_ready), 64'd0);
        end
      end
    end
  end

  task automatic do_txn(input logic [63:0] a, input logic [63:0] d, input logic [1:0] sz,
                        input int awd, input int wd, input int bd,
                        input logic [1:0] br, input logic [12:0] bi, input bit rst_mid);
    int nb, off, lat, k;
    bit mis, got;
    logic [63:0] sh;
    aw_exp_t ea;
    w_exp_t  ew;
    d_exp_t  ed;
    k = 0;
    @(negedge clk);
    while (!req_ready && k < 100) begin @(negedge clk); k++; end
    if (!req_ready) begin fail_now("req_ready_wait"); return; end
    // Reference model: byte count, lane offset, arithmetic placement
    nb  = 1 << sz;
    off = int'(a % 8);
    mis = ((off % nb) != 0) || (off + nb > 8);
    sh  = 64'd1 << (8 * off);
    ea.addr = a; ea.size = sz;
    ew.data = d * sh;
    ew.strb = 8'(((1 << nb) - 1) * (1 << off));
    lat = mis ? 1 : (((awd > wd) ? awd : wd) + 2 + bd);
    ed.err = mis || (br != 2'b00) || (bi != WR_ID);
    ed.lat = lat;
    if (!mis) begin aw_q.push_back(ea); w_q.push_back(ew); end
    d_q.push_back(ed);
    cur_aw_d = awd; cur_w_d = wd; cur_b_d = bd; cur_bresp = br; cur_bid = bi;
    t0 = cyc;
    req_valid = 1; req_addr = a; req_data = d; req_size = sz;
    got = 0; k = 0;
    while (k < 100 && !got) begin
      @(negedge clk);
      k++;
      if (rst_mid && bready) begin
        req_valid = 0;
        #2 reset = 1;
        #1;
        chk("rst_bready", 64'(bready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        aw_q.delete(); w_q.delete(); d_q.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 0;
        return;
      end
      if (done) begin
        got = 1;
        req_valid = 0;
      end else begin
        // Requests while busy must be ignored; junk here would show up as extra traffic
        req_valid = 1'($urandom_range(0, 1));
        req_addr  = {$urandom, $urandom};
        req_data  = {$urandom, $urandom};
        req_size  = 2'($urandom_range(0, 3));
      end
    end
    if (!got) begin req_valid = 0; fail_now("done_wait"); end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [63:0] a, d;
    logic [1:0]  sz, br;
    logic [12:0] bi;
    reset = 1; req_valid = 0; req_addr = 0; req_data = 0; req_size = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_req_ready", 64'(req_ready), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_valids", {62'd0, awvalid, wvalid}, 64'd0);
    chk("reset_bready", 64'(bready), 64'd0);
    reset = 0;
    @(negedge clk);
    #1;
    chk("idle_req_ready", 64'(req_ready), 64'd1);

    do_txn(64'h1000, 64'h1122334455667788, 2'd3, 1, 1, 0, 2'b00, WR_ID, 0);
    do_txn(64'h1005, 64'h00000000000000AB, 2'd0, 1, 1, 0, 2'b00, WR_ID, 0);
    do_txn(64'h2002, 64'h000000000000BEEF, 2'd1, 1, 4, 0, 2'b00, WR_ID, 0);
    do_txn(64'h1006, 64'h00000000CAFEF00D, 2'd2, 1, 1, 0, 2'b00, WR_ID, 0);
    do_txn(64'h3004, 64'h0000000012345678, 2'd2, 2, 1, 1, 2'b10, WR_ID, 0);
    do_txn(64'h3008, 64'h0123456789ABCDEF, 2'd3, 1, 2, 0, 2'b00, WR_ID + 13'd1, 0);
    do_txn(64'h4000, 64'hDEADBEEF00000000, 2'd3, 1, 1, 6, 2'b00, WR_ID, 1);
    do_txn(64'h4006, 64'h0000000000005A5A, 2'd1, 1, 1, 0, 2'b00, WR_ID, 0);

    for (int i = 0; i < 200; i++) begin
      a  = {$urandom, $urandom};
      d  = {$urandom, $urandom};
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) a[2:0] = a[2:0] & ~3'((1 << sz) - 1);
      br = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      bi = ($urandom_range(0, 7) == 0) ? WR_ID + 13'd1 : WR_ID;
      do_txn(a, d, sz, $urandom_range(1, 4), $urandom_range(1, 4),
             $urandom_range(0, 3), br, bi, 0);
    end

    repeat (4) @(negedge clk);
    chk("aw_q_drained", 64'(aw_q.size()), 64'd0);
    chk("w_q_drained", 64'(w_q.size()), 64'd0);
    chk("done_q_drained", 64'(d_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
